// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot pixel scheduler: fixed-point format and FSM states.
package mandel_pkg;

  localparam int COORD_W   = 27;
  localparam int FRAC_BITS = 23;
  localparam int ITER_W    = 13;

  // 1.0 in signed 4.23
  localparam logic signed [COORD_W-1:0] ONE = COORD_W'(1 << FRAC_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_WRITE,
    S_ADVANCE,
    S_DONE
  } state_t;

endpackage

// File: rtl/mandel_coord_stepper.sv
// Raster-order pixel walker: x/y/address counters plus cr/ci accumulators in signed 4.23.
module mandel_coord_stepper #(
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 480,
  parameter int COORD_W  = mandel_pkg::COORD_W,
  parameter int ADDR_W   = 19
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic                      step,
  input  logic signed [COORD_W-1:0] cr_min,
  input  logic signed [COORD_W-1:0] ci_max,
  input  logic signed [COORD_W-1:0] dx,
  input  logic signed [COORD_W-1:0] dy,
  output logic signed [COORD_W-1:0] cr,
  output logic signed [COORD_W-1:0] ci,
  output logic [ADDR_W-1:0]         addr,
  output logic                      last_pixel
);

  localparam int X_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int Y_W = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_PIXELS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_PIXELS - 1);

  logic [X_W-1:0]            x;
  logic [Y_W-1:0]            y;
  logic signed [COORD_W-1:0] cr_min_q;
  logic signed [COORD_W-1:0] dx_q;
  logic signed [COORD_W-1:0] dy_q;

  // Plain two's-complement wrap; the solver is expected to cope with any coordinate.
  function automatic logic signed [COORD_W-1:0] wrap_add(
    input logic signed [COORD_W-1:0] a,
    input logic signed [COORD_W-1:0] b
  );
    return a + b;
  endfunction

  function automatic logic signed [COORD_W-1:0] wrap_sub(
    input logic signed [COORD_W-1:0] a,
    input logic signed [COORD_W-1:0] b
  );
    return a - b;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      addr     <= '0;
      cr       <= '0;
      ci       <= '0;
      cr_min_q <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
    end else if (init) begin
      x        <= '0;
      y        <= '0;
      addr     <= '0;
      cr       <= cr_min;
      ci       <= ci_max;
      cr_min_q <= cr_min;
      dx_q     <= dx;
      dy_q     <= dy;
    end else if (step) begin
      if (x != X_LAST) begin
        x  <= x + 1'b1;
        cr <= wrap_add(cr, dx_q);
      end else begin
        x  <= '0;
        cr <= cr_min_q;
        y  <= y + 1'b1;
        ci <= wrap_sub(ci, dy_q);
      end
      addr <= addr + 1'b1;
    end
  end

  assign last_pixel = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/mandel_pixel_scheduler.sv
// Frame initiator for one Mandelbrot solver: walks the pixel grid, runs the solver per pixel
// and hands each iteration count to the frame-buffer writer over valid/ready.
module mandel_pixel_scheduler #(
  parameter int H_PIXELS     = 640,
  parameter int V_PIXELS     = 480,
  parameter int COORD_W      = mandel_pkg::COORD_W,
  parameter int ITER_W       = mandel_pkg::ITER_W,
  parameter int ADDR_W       = 19,
  parameter int RESET_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [COORD_W-1:0] cr_min,
  input  logic signed [COORD_W-1:0] ci_max,
  input  logic signed [COORD_W-1:0] dx,
  input  logic signed [COORD_W-1:0] dy,
  input  logic [ITER_W-1:0]         max_iter,
  output logic                      solver_reset,
  output logic signed [COORD_W-1:0] solver_cr,
  output logic signed [COORD_W-1:0] solver_ci,
  output logic [ITER_W-1:0]         solver_max_iter,
  input  logic [ITER_W-1:0]         solver_iter,
  input  logic                      solver_done,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic [ADDR_W-1:0]         pix_addr,
  output logic [ITER_W-1:0]         pix_iter,
  output logic                      busy,
  output logic                      frame_done
);

  import mandel_pkg::*;

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);

  state_t                    state;
  state_t                    state_nxt;
  logic [RC_W-1:0]           rst_cnt;
  logic                      wait_armed;
  logic [ITER_W-1:0]         max_iter_q;
  logic                      init;
  logic                      step;
  logic                      last_pixel;
  logic                      done_honoured;

  assign init = (state == S_IDLE) && start;
  assign step = (state == S_ADVANCE);
  // The first WAIT cycle may still see done from the previous pixel, so it is never honoured.
  assign done_honoured = (state == S_WAIT) && wait_armed && solver_done;

  mandel_coord_stepper #(
    .H_PIXELS (H_PIXELS),
    .V_PIXELS (V_PIXELS),
    .COORD_W  (COORD_W),
    .ADDR_W   (ADDR_W)
  ) u_stepper (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .step       (step),
    .cr_min     (cr_min),
    .ci_max     (ci_max),
    .dx         (dx),
    .dy         (dy),
    .cr         (solver_cr),
    .ci         (solver_ci),
    .addr       (pix_addr),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      rst_cnt    <= '0;
      wait_armed <= 1'b0;
      max_iter_q <= '0;
      pix_iter   <= '0;
    end else begin
      state      <= state_nxt;
      rst_cnt    <= (state == S_LOAD) ? rst_cnt + 1'b1 : '0;
      wait_armed <= (state == S_WAIT);
      if (init) begin
        max_iter_q <= max_iter;
      end
      if (done_honoured) begin
        pix_iter <= solver_iter;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    solver_reset = 1'b1;
    pix_valid    = 1'b0;
    busy         = 1'b1;
    frame_done   = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (rst_cnt == RC_LAST) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        solver_reset = 1'b0;
        if (done_honoured) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        solver_reset = 1'b0;
        pix_valid    = 1'b1;
        if (pix_ready) state_nxt = S_ADVANCE;
      end
      S_ADVANCE: begin
        state_nxt = last_pixel ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        busy       = 1'b0;
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign solver_max_iter = max_iter_q;

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Scoreboard bench for mandel_pixel_scheduler on a 2x2 grid with a fixed-latency solver model.
module tb_mandel_pixel_scheduler;
  import mandel_pkg::*;

  localparam int H = 2, V = 2, AW = 19, RC = 2, LAT = 3;
  localparam int P1 = 8388608;   // 1.0
  localparam int PH = 4194304;   // 0.5

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, pix_ready = 1'b1;
  logic signed [COORD_W-1:0] cr_min = '0, ci_max = '0, dx = '0, dy = '0;
  logic [ITER_W-1:0] max_iter = '0;
  logic solver_reset, pix_valid, busy, frame_done;
  logic signed [COORD_W-1:0] solver_cr, solver_ci;
  logic [ITER_W-1:0] solver_max_iter, pix_iter;
  logic [ITER_W-1:0] solver_iter = '0;
  logic solver_done = 1'b0;
  logic [AW-1:0] pix_addr;

  always #5 clk = ~clk;

  mandel_pixel_scheduler #(
    .H_PIXELS(H), .V_PIXELS(V), .COORD_W(COORD_W), .ITER_W(ITER_W),
    .ADDR_W(AW), .RESET_CYCLES(RC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cr_min(cr_min), .ci_max(ci_max),
    .dx(dx), .dy(dy), .max_iter(max_iter), .solver_reset(solver_reset),
    .solver_cr(solver_cr), .solver_ci(solver_ci), .solver_max_iter(solver_max_iter),
    .solver_iter(solver_iter), .solver_done(solver_done), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_addr(pix_addr), .pix_iter(pix_iter), .busy(busy),
    .frame_done(frame_done)
  );

  int n_tests = 0, n_fail = 0;
  int cyc = 0, fd_cnt = 0, last_xfer_cyc = 0;
  logic [AW-1:0] last_xfer_addr = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural solver: fixed latency, per-solve iteration table, optional sticky done.
  logic [ITER_W-1:0] iter_tab [4];
  bit stale_mode = 1'b0;
  logic model_restart = 1'b0;
  logic [7:0] m_cnt = '0;
  int solve_idx = 0;

  always @(posedge clk) begin
    if (model_restart) solve_idx <= 0;
    if (solver_reset) begin
      m_cnt <= '0;
      if (!stale_mode) solver_done <= 1'b0;
    end else begin
      if (m_cnt != 8'hff) m_cnt <= m_cnt + 8'd1;
      if (m_cnt == 8'(LAT - 1)) begin
        solver_done <= 1'b1;
        solver_iter <= iter_tab[solve_idx % 4];
        solve_idx   <= solve_idx + 1;
      end else if (m_cnt == 8'd0) begin
        solver_done <= 1'b0;
      end
    end
  end

  always @(posedge clk) cyc++;

  typedef struct { logic [AW-1:0] addr; logic [ITER_W-1:0] iter; } pix_t;
  typedef struct { logic signed [COORD_W-1:0] cr, ci; logic [ITER_W-1:0] mi; bit chk_run; } coord_t;
  pix_t   pix_q[$];
  coord_t coord_q[$];
  pix_t   pe;
  coord_t ce;

  // Pixel output monitor
  always @(negedge clk) begin
    if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
      if (pix_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_pixel: got addr %0d iter %0d, none expected", pix_addr, pix_iter);
      end else begin
        pe = pix_q.pop_front();
        check("pix_addr", pix_addr, pe.addr);
        check("pix_iter", pix_iter, pe.iter);
      end
      last_xfer_cyc  = cyc;
      last_xfer_addr = pix_addr;
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      check("frame_done_gap_after_last_xfer", cyc - last_xfer_cyc, 2);
      check("frame_done_last_addr", last_xfer_addr, H * V - 1);
    end
  end

  // Solver-start monitor: coordinates/limit at each solver_reset fall, and hold length
  logic prev_sr = 1'b0;
  logic signed [COORD_W-1:0] prev_cr = '0, prev_ci = '0;
  int run = 0;
  always @(negedge clk) begin
    if (prev_sr === 1'b1 && solver_reset === 1'b0) begin
      if (coord_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_solver_start: got cr %0d ci %0d, none expected", solver_cr, solver_ci);
      end else begin
        ce = coord_q.pop_front();
        check("solver_cr", solver_cr, ce.cr);
        check("solver_ci", solver_ci, ce.ci);
        check("solver_max_iter", solver_max_iter, ce.mi);
        if (ce.chk_run) check("reset_hold_stable_cycles", run, RC);
      end
    end
    if (solver_reset === 1'b1) begin
      if (prev_sr === 1'b1 && solver_cr == prev_cr && solver_ci == prev_ci) run++;
      else run = 1;
    end
    prev_sr = solver_reset;
    prev_cr = solver_cr;
    prev_ci = solver_ci;
  end

  task automatic push_frame(input int ecr[4], input int eci[4], input int mi, input bit chk);
    coord_t c;
    pix_t p;
    for (int k = 0; k < 4; k++) begin
      c.cr = COORD_W'(ecr[k]); c.ci = COORD_W'(eci[k]); c.mi = ITER_W'(mi); c.chk_run = chk;
      coord_q.push_back(c);
      p.addr = AW'(k); p.iter = iter_tab[k];
      pix_q.push_back(p);
    end
  endtask

  task automatic start_frame(input int c0, input int i0, input int ddx, input int ddy, input int mi);
    @(posedge clk); #1;
    cr_min = COORD_W'(c0); ci_max = COORD_W'(i0); dx = COORD_W'(ddx); dy = COORD_W'(ddy);
    max_iter = ITER_W'(mi);
    start = 1'b1; model_restart = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; model_restart = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_frame(input string name);
    int target;
    target = fd_cnt + 1;
    for (int i = 0; i < 2000 && fd_cnt < target; i++) @(posedge clk);
    check({name, "_frame_done_seen"}, fd_cnt, target);
    repeat (5) @(posedge clk);
    check({name, "_single_frame_done"}, fd_cnt, target);
    @(negedge clk);
    check({name, "_busy_idle"}, busy, 0);
    check({name, "_pixels_left"}, pix_q.size(), 0);
    check({name, "_starts_left"}, coord_q.size(), 0);
  endtask

  task automatic wait_solver_running(input string name);
    for (int i = 0; i < 200 && solver_reset !== 1'b0; i++) begin
      @(posedge clk); #1;
    end
    check({name, "_solver_running"}, solver_reset, 0);
  endtask

  initial begin
    logic [AW-1:0] hold_addr;
    logic [ITER_W-1:0] hold_iter;
    bit found;
    int fd_before;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_solver_reset", solver_reset, 1);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_solver_cr", solver_cr, 0);
    check("rst_solver_ci", solver_ci, 0);
    check("rst_solver_max_iter", solver_max_iter, 0);
    check("rst_pix_addr", pix_addr, 0);
    check("rst_pix_iter", pix_iter, 0);

    // Frame walk: (-2,1) (-1.5,1) (-2,0.5) (-1.5,0.5)
    iter_tab = '{13'd10, 13'd11, 13'd12, 13'd13};
    push_frame('{-2*P1, -2*P1+PH, -2*P1, -2*P1+PH}, '{P1, P1, PH, PH}, 100, 1'b1);
    start_frame(-2*P1, P1, PH, PH, 100);
    wait_frame("walk");

    // Sticky done from the previous solve plus limit passthrough and mid-frame input change
    stale_mode = 1'b1;
    iter_tab = '{13'd1000, 13'd7, 13'd1000, 13'd7};
    push_frame('{0, 0, 0, 0}, '{0, 0, 0, 0}, 1000, 1'b0);
    start_frame(0, 0, 0, 0, 1000);
    #1 max_iter = 13'd5; cr_min = COORD_W'(P1); dx = COORD_W'(P1);
    wait_frame("stale_limit");

    // Start during WAIT ignored, then backpressure on pixel 1
    iter_tab = '{13'd20, 13'd21, 13'd22, 13'd23};
    push_frame('{-2*P1, -2*P1+PH, -2*P1, -2*P1+PH}, '{P1, P1, PH, PH}, 50, 1'b0);
    start_frame(-2*P1, P1, PH, PH, 50);
    wait_solver_running("misuse");
    start = 1'b1; cr_min = '0; ci_max = '0; dx = COORD_W'(3 * P1); max_iter = 13'd9;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (pix_valid === 1'b1 && pix_addr == AW'(1)) found = 1'b1;
    end
    check("bp_reached_pixel1", found, 1);
    pix_ready = 1'b0;
    hold_addr = pix_addr;
    hold_iter = pix_iter;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", pix_valid, 1);
      check("bp_addr_stable", pix_addr, hold_addr);
      check("bp_iter_stable", pix_iter, hold_iter);
      check("bp_solver_reset_low", solver_reset, 0);
      @(posedge clk); #1;
    end
    pix_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_on_ready", pix_valid, 1);
    @(posedge clk); #1;
    check("bp_valid_drops_after_xfer", pix_valid, 0);
    wait_frame("backpressure");

    // Reset in the middle of WAIT: abandons the frame with nothing emitted
    stale_mode = 1'b0;
    begin
      coord_t c;
      c.cr = COORD_W'(P1); c.ci = COORD_W'(-P1); c.mi = 13'd77; c.chk_run = 1'b0;
      coord_q.push_back(c);
    end
    start_frame(P1, -P1, PH, PH, 77);
    wait_solver_running("midreset");
    fd_before = fd_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_solver_reset", solver_reset, 1);
    check("midreset_pix_valid", pix_valid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_frame_done", frame_done, 0);
    check("midreset_pix_iter", pix_iter, 0);
    check("midreset_pix_addr", pix_addr, 0);
    check("midreset_solver_max_iter", solver_max_iter, 0);
    repeat (20) @(posedge clk);
    check("midreset_no_frame_done", fd_cnt, fd_before);
    check("midreset_still_idle", busy, 0);
    check("midreset_starts_left", coord_q.size(), 0);

    // Column step wraps 7.5-ish + 1.0 into the negative range
    iter_tab = '{13'd1, 13'd2, 13'd3, 13'd4};
    push_frame('{62914559, -62914561, 62914559, -62914561}, '{0, 0, 0, 0}, 40, 1'b0);
    start_frame(62914559, 0, P1, 0, 40);
    wait_frame("wrap");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
